capture_buffer: RTL and testbench
=================================

# capture_buffer

Trigger-aligned acquisition stage that sits directly upstream of the frame filter. It takes the signed 12-bit ADC sample stream, waits for a programmable level crossing, and freezes a 256-sample frame with a fixed pre-trigger depth. It presents the frame as a parallel array with a valid/ack handshake to the filter and display path.

## Interface
- `PRE_SAMPLES`, default 64: samples kept before the trigger sample; legal range 1..254.
- `AUTO_TIMEOUT`, default 4096: accepted samples in WAIT_TRIG before a forced trigger; used only with the macro.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high; clock `clk`.
- `sample`  in  12  signed ADC sample.
- `sample_valid`  in  1  `sample` is accepted this cycle.
- `arm`  in  1  level; high enables capture and re-arm; low aborts.
- `trig_level`  in  12  signed trigger threshold.
- `trig_falling`  in  1  0 = rising edge, 1 = falling edge.
- `frame_ack`  in  1  consumer has taken the frame; honoured only in DONE.
- `frame`  out  12 x [0:255]  captured frame; [0] is the oldest sample, [255] the newest.
- `frame_valid`  out  1  frame is complete and frozen.
- `busy`  out  1  state is FILL, WAIT_TRIG or POST.
- `trig_forced`  out  1  current frame was produced by timeout.

## Operation
- Storage is a 256-entry shift register. An accepted sample shifts `frame[i] <= frame[i+1]` and `frame[255] <= sample`. Shifting happens only in FILL, WAIT_TRIG and POST.
- `prev` is `frame[255]` before the shift.
- Rising trigger: `prev < trig_level && sample >= trig_level`, compared signed.
- Falling trigger: `prev > trig_level && sample <= trig_level`, compared signed.
- State IDLE: if `arm` is high, go to FILL and clear `fill_cnt`.
- State FILL: count accepted samples. When `fill_cnt` reaches `PRE_SAMPLES`, go to WAIT_TRIG.
- State WAIT_TRIG: evaluate the trigger on each accepted sample. On a hit, the triggering sample is shifted in, `post_cnt` is cleared and the state goes to POST.
- State POST: count accepted samples. The sample that makes `post_cnt == 255-PRE_SAMPLES` is the last one; go to DONE.
- Result: the trigger sample lands at `frame[PRE_SAMPLES]`.
- State DONE: `frame` is frozen and `sample_valid` is ignored. On `frame_ack`, go to FILL if `arm` is high, otherwise go to IDLE. `frame_valid` clears.
- `arm` low in FILL, WAIT_TRIG or POST: go to IDLE on the next edge. `frame_valid` stays 0; `frame` keeps partial contents.
- `arm` low in DONE has no effect until `frame_ack` arrives.
- `frame_ack` outside DONE is ignored.
- `frame_ack` and `arm` low in the same cycle in DONE: go to IDLE.
- Counters are 9 bits wide and never wrap; the state change occurs at the terminal count.

## Timing
- Reset values: state IDLE, every `frame[i]` = 0, `frame_valid` = 0, `busy` = 0, `trig_forced` = 0, all counters 0.
- The trigger is evaluated combinationally in the same cycle the sample is presented. The state changes on that edge.
- `frame_valid` rises on the edge that shifts in the last post-trigger sample. It is visible the following cycle.
- Minimum acquisition time is 256 accepted samples after entering FILL.
- `frame_valid` falls one cycle after `frame_ack` is sampled high.
- The earliest new sample is accepted the cycle after that ack edge.
- `rst` mid-capture returns the block to the reset values on the next edge, regardless of state.

## Configuration
- Macro `CAPTURE_AUTO_TRIG_EN`.
- Defined:
  - A 16-bit `to_cnt` counts accepted samples in WAIT_TRIG and clears on entering WAIT_TRIG.
  - When `to_cnt` reaches `AUTO_TIMEOUT-1`, the sample accepted on that cycle is treated as the trigger.
  - `trig_forced` is set on entry to POST and cleared on leaving DONE.
  - A real edge on the same sample takes priority; `trig_forced` = 0 in that case.
- Undefined: no timeout counter, WAIT_TRIG waits indefinitely, `trig_forced` tied to 0, `AUTO_TIMEOUT` unused.

## Structure
- Shared package `osc_pkg`:
  - `SAMPLE_W` = 12
  - `FRAME_LEN` = 256
  - `typedef logic signed [SAMPLE_W-1:0] sample_t`
  - `typedef sample_t frame_t [0:FRAME_LEN-1]`
  - `cap_state_t` enum: IDLE, FILL, WAIT_TRIG, POST, DONE
- The filter stage imports the same package.
- One sub-module, `trigger_detect`: combinational signed edge comparator with inputs `prev`, `sample`, `trig_level`, `trig_falling` and output `hit`.

## Test plan
- Rising ramp with `sample_valid` every cycle, `PRE_SAMPLES` = 64, level 0, samples -200, -199, ... -> `frame[64]` = 0, `frame[0]` = -64, `frame[255]` = 191, `frame_valid` high.
- Falling, level 100, sine of amplitude 1000 with `sample_valid` every 3rd cycle -> `frame[64] <= 100` and `frame[63] > 100`; exactly 256 accepted samples spanned.
- Constant input 5 with level 0 and the macro defined -> forced trigger after 4096 WAIT_TRIG samples, `trig_forced` = 1, every frame entry = 5. Without the macro, `frame_valid` never rises within 10000 samples.
- `arm` dropped 20 samples into POST -> IDLE next cycle, `frame_valid` stays 0, `busy` = 0. Re-arming yields a correct fresh frame.
- In DONE, further samples -> `frame` unchanged. `frame_ack` with `arm` high -> `frame_valid` = 0 next cycle and FILL restarts. `frame_ack` in WAIT_TRIG is ignored.
- `rst` asserted in WAIT_TRIG -> all frame entries and outputs 0, state IDLE.

Source files
------------

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared sample, frame and capture-state types for the scope datapath
package osc_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int FRAME_LEN = 256;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t frame_t [0:FRAME_LEN-1];

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/trigger_detect.sv
// rtl/trigger_detect.sv - signed level-crossing comparator between the previous and current sample
module trigger_detect
  import osc_pkg::*;
(
  input  sample_t prev,
  input  sample_t sample,
  input  sample_t trig_level,
  input  logic    trig_falling,
  output logic    hit
);

  always_comb begin
    if (trig_falling) begin
      hit = (prev > trig_level) && (sample <= trig_level);
    end else begin
      hit = (prev < trig_level) && (sample >= trig_level);
    end
  end

endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - trigger-aligned 256-sample capture; CAPTURE_AUTO_TRIG_EN adds a WAIT_TRIG timeout trigger
module capture_buffer
  import osc_pkg::*;
#(
  parameter int PRE_SAMPLES  = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample,
  input  logic    sample_valid,
  input  logic    arm,
  input  sample_t trig_level,
  input  logic    trig_falling,
  input  logic    frame_ack,
  output frame_t  frame,
  output logic    frame_valid,
  output logic    busy,
  output logic    trig_forced
);

  localparam logic [8:0] FILL_LAST = 9'(PRE_SAMPLES);
  localparam logic [8:0] POST_LAST = 9'(255 - PRE_SAMPLES);

  cap_state_t state_q, state_d;
  logic [8:0] fill_cnt_q, fill_cnt_d;
  logic [8:0] post_cnt_q, post_cnt_d;
  logic       frame_valid_d;
  logic       trig_forced_q, trig_forced_d;
  logic       shift_en;
  logic       hit;
  logic       forced;

  trigger_detect u_trigger_detect (
    .prev         (frame[FRAME_LEN-1]),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .hit          (hit)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam logic [15:0] TO_LAST = 16'(AUTO_TIMEOUT - 1);

  logic [15:0] to_cnt_q, to_cnt_d;

  // A genuine edge on the timeout sample wins, so forced stays low then.
  assign forced = !hit && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != WAIT_TRIG) begin
      to_cnt_d = '0;
    end else if (arm && sample_valid) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (AUTO_TIMEOUT != 0);
  assign forced     = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    post_cnt_d    = post_cnt_q;
    frame_valid_d = frame_valid;
    trig_forced_d = trig_forced_q;
    shift_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      FILL: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          shift_en   = 1'b1;
          fill_cnt_d = fill_cnt_q + 9'd1;
          if (fill_cnt_d == FILL_LAST) begin
            state_d = WAIT_TRIG;
          end
        end
      end
      WAIT_TRIG: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          shift_en = 1'b1;
          if (hit || forced) begin
            state_d       = POST;
            post_cnt_d    = '0;
            trig_forced_d = forced;
          end
        end
      end
      POST: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          shift_en   = 1'b1;
          post_cnt_d = post_cnt_q + 9'd1;
          if (post_cnt_d == POST_LAST) begin
            state_d       = DONE;
            frame_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        // arm is only consulted once the consumer releases the frame
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          trig_forced_d = 1'b0;
          if (arm) begin
            state_d    = FILL;
            fill_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fill_cnt_q    <= '0;
      post_cnt_q    <= '0;
      frame_valid   <= 1'b0;
      trig_forced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      post_cnt_q    <= post_cnt_d;
      frame_valid   <= frame_valid_d;
      trig_forced_q <= trig_forced_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        frame[i] <= '0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        frame[i] <= frame[i+1];
      end
      frame[FRAME_LEN-1] <= sample;
    end
  end

  assign busy        = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign trig_forced = trig_forced_q;

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - directed self-checking bench for capture_buffer
module tb_capture_buffer;
  import osc_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  sample_t sample;
  logic    sample_valid;
  logic    arm;
  sample_t trig_level;
  logic    trig_falling;
  logic    frame_ack;
  frame_t  frame;
  logic    frame_valid;
  logic    busy;
  logic    trig_forced;

  int n_checks = 0;
  int n_errors = 0;

  capture_buffer #(
    .PRE_SAMPLES  (64),
    .AUTO_TIMEOUT (4096)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .frame_ack    (frame_ack),
    .frame        (frame),
    .frame_valid  (frame_valid),
    .busy         (busy),
    .trig_forced  (trig_forced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input int gap);
    sample       = sample_t'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  int q[$];
  int k;
  int errs;
  int n;
  int seen;
  int v;

  initial begin
    rst = 1'b1; sample = '0; sample_valid = 1'b0; arm = 1'b0;
    trig_level = '0; trig_falling = 1'b0; frame_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_frame0", frame[0], 0);
    check("rst_frame255", frame[255], 0);
    check("rst_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_forced", trig_forced, 0);

    // rising ramp, level 0: trigger on sample 0
    arm = 1'b1;
    tick();
    check("arm_busy", busy, 1);
    for (int s = -200; s <= 191; s++) begin
      if (s == 191) check("ramp_not_early", frame_valid, 0);
      push(s, 0);
    end
    check("ramp_valid", frame_valid, 1);
    check("ramp_f64", frame[64], 0);
    check("ramp_f0", frame[0], -64);
    check("ramp_f255", frame[255], 191);
    check("ramp_f128", frame[128], 64);
    check("ramp_busy", busy, 0);
    check("ramp_forced", trig_forced, 0);

    // DONE ignores further samples
    push(999, 0); push(-999, 0); push(7, 0);
    check("done_f255", frame[255], 191);
    check("done_f0", frame[0], -64);
    check("done_valid", frame_valid, 1);
    ack();
    check("ack_valid", frame_valid, 0);
    check("ack_refill", busy, 1);

    // falling sine, level 100, one sample every third cycle; trigger at k=75
    trig_falling = 1'b1;
    trig_level   = sample_t'(100);
    k = 0;
    while (!frame_valid && k < 2000) begin
      v = int'($floor(1000.0 * $sin(2.0 * 3.14159265358979 * k / 50.0) + 0.5));
      q.push_back(v);
      push(v, 2);
      if (k == 70) begin
        ack();
        check("ack_wait_busy", busy, 1);
        check("ack_wait_valid", frame_valid, 0);
      end
      k++;
    end
    check("sine_valid", frame_valid, 1);
    check("sine_count", k, 267);
    check("sine_f64", frame[64], 0);
    check("sine_f63", frame[63], 125);
    errs = 0;
    if (q.size() >= 256) begin
      for (int i = 0; i < 256; i++) begin
        if (int'(frame[i]) != q[q.size() - 256 + i]) errs++;
      end
    end else begin
      errs = 256;
    end
    check("sine_span", errs, 0);

    // abort 20 samples into POST, then re-arm
    ack();
    trig_falling = 1'b0;
    trig_level   = '0;
    for (int s = -200; s <= 20; s++) push(s, 0);
    arm = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", frame_valid, 0);
    check("abort_f255", frame[255], 20);
    repeat (3) tick();
    check("abort_valid_hold", frame_valid, 0);
    trig_level = sample_t'(50);
    arm = 1'b1;
    tick();
    for (int s = -100; s <= 241; s++) push(s, 0);
    check("rearm_valid", frame_valid, 1);
    check("rearm_f64", frame[64], 50);
    check("rearm_f0", frame[0], -14);
    check("rearm_f255", frame[255], 241);

    // constant input: only a timeout can trigger
    ack();
    trig_level = '0;
`ifdef CAPTURE_AUTO_TRIG_EN
    n = 0;
    while (!frame_valid && n < 10000) begin
      push(5, 0);
      n++;
    end
    check("auto_count", n, 4351);
    check("auto_forced", trig_forced, 1);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (frame[i] !== sample_t'(5)) errs++;
    end
    check("auto_all5", errs, 0);
`else
    seen = 0;
    repeat (10000) begin
      push(5, 0);
      if (frame_valid) seen = 1;
    end
    check("noauto_valid", seen, 0);
    check("noauto_busy", busy, 1);
    check("noauto_forced", trig_forced, 0);
`endif

    // reach WAIT_TRIG, then reset mid-capture
    ack();
    for (int i = 0; i < 100; i++) push(5, 0);
    check("wait_busy", busy, 1);
    check("wait_valid", frame_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_f0", frame[0], 0);
    check("rst2_f128", frame[128], 0);
    check("rst2_f255", frame[255], 0);
    check("rst2_valid", frame_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_forced", trig_forced, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
